// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        LOAD = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } loader_state_t;

    // Length header is a 32-bit little-endian byte count.
    localparam int unsigned LOADER_HDR_BYTES = 4;
    localparam int unsigned CNT_WIDTH        = 32;

endpackage

// File: rtl/byte_word_packer.sv
// Assembles bytes into a word by lane; the output already includes the byte
// being shifted this cycle so the caller can capture a complete word at once.
module byte_word_packer #(
    parameter int unsigned InstrWidth = 32,
    parameter int unsigned EntryWidth = 8,
    parameter int unsigned LaneWidth  = $clog2(InstrWidth / EntryWidth)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [EntryWidth-1:0] data_byte,
    input  logic [LaneWidth-1:0]  lane,
    input  logic                  shift,
    output logic [InstrWidth-1:0] word_c
);

    logic [InstrWidth-1:0] word_q;

    // Hold previously received lanes of the word being built.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_q <= '0;
        end else if (shift) begin
            word_q[32'(lane) * EntryWidth +: EntryWidth] <= data_byte;
        end
    end

    // Merge the byte arriving this cycle into the stored lanes.
    always_comb begin
        word_c = word_q;
        if (shift) begin
            word_c[32'(lane) * EntryWidth +: EntryWidth] = data_byte;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: takes a length-prefixed byte stream, writes it into imem as
// little-endian words and releases the core once a full image has landed.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned IMemCacheLen = 8192,
    parameter int unsigned InstrWidth   = 32,
    parameter int unsigned EntryWidth   = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [EntryWidth-1:0]           rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic                            mem_wr_en,
    output logic [$clog2(IMemCacheLen)-1:0] mem_wr_addr,
    output logic [InstrWidth-1:0]           mem_wr_data,
    output logic                            core_rst,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);

    localparam int unsigned AddrWidth    = $clog2(IMemCacheLen);
    localparam int unsigned BytesPerWord = InstrWidth / EntryWidth;
    localparam int unsigned LaneWidth    = $clog2(BytesPerWord);

    loader_state_t          state, state_nxt;
    logic [CNT_WIDTH-1:0]   cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0]   len, len_nxt;
    logic [InstrWidth-1:0]  packed_c;
    logic                   xfer, hdr_last, len_bad, word_last;
    logic                   rx_ready_nxt, wr_en_nxt, core_rst_nxt;
    logic                   busy_nxt, done_nxt, error_nxt;
    logic [AddrWidth-1:0]   wr_addr_nxt;
    logic [InstrWidth-1:0]  wr_data_nxt;

    assign xfer      = rx_valid & rx_ready;
    assign hdr_last  = (state == HDR) && xfer && (cnt == CNT_WIDTH'(LOADER_HDR_BYTES - 1));
    assign word_last = (state == LOAD) && xfer
                       && (cnt[LaneWidth-1:0] == LaneWidth'(BytesPerWord - 1));
    // Length must be non-zero, whole words, and fit in imem (32-bit compare).
    assign len_bad   = (packed_c == '0)
                       || (packed_c[LaneWidth-1:0] != '0)
                       || (CNT_WIDTH'(packed_c) > CNT_WIDTH'(IMemCacheLen));

    // One packer serves both the length header and the payload words.
    byte_word_packer #(
        .InstrWidth (InstrWidth),
        .EntryWidth (EntryWidth),
        .LaneWidth  (LaneWidth)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .data_byte (rx_data),
        .lane      (cnt[LaneWidth-1:0]),
        .shift     (xfer),
        .word_c    (packed_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured outside HDR/LOAD.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = HDR;
            HDR:     if (hdr_last) state_nxt = len_bad ? ERR : LOAD;
            LOAD:    if (cnt == len) state_nxt = DONE;
            DONE:    if (start) state_nxt = HDR;
            ERR:     if (start) state_nxt = HDR;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values for counters, write port and status outputs.
    always_comb begin
        cnt_nxt      = cnt;
        len_nxt      = len;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = mem_wr_addr;
        wr_data_nxt  = mem_wr_data;

        if ((state_nxt == HDR) && (state != HDR)) begin
            cnt_nxt = '0;
        end else if (hdr_last) begin
            cnt_nxt = '0;
            len_nxt = CNT_WIDTH'(packed_c);
        end else if (xfer) begin
            cnt_nxt = cnt + CNT_WIDTH'(1);
        end

        if (word_last) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = AddrWidth'({cnt[CNT_WIDTH-1:LaneWidth], LaneWidth'(0)});
            wr_data_nxt = packed_c;
        end

        rx_ready_nxt = (state_nxt == HDR) || ((state_nxt == LOAD) && (cnt_nxt != len_nxt));
        busy_nxt     = (state_nxt == HDR) || (state_nxt == LOAD);
        done_nxt     = (state_nxt == DONE);
        error_nxt    = (state_nxt == ERR);
        core_rst_nxt = (state_nxt != DONE);
    end

    // Registered datapath and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            len         <= '0;
            rx_ready    <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            core_rst    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            cnt         <= cnt_nxt;
            len         <= len_nxt;
            rx_ready    <= rx_ready_nxt;
            mem_wr_en   <= wr_en_nxt;
            mem_wr_addr <= wr_addr_nxt;
            mem_wr_data <= wr_data_nxt;
            core_rst    <= core_rst_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            error       <= error_nxt;
        end
    end

endmodule
